axi_reorder_remap_cmp: RTL and testbench

AXI_REORDER_REMAP_CMP -- requirements
Module: axi_reorder_remap_cmp

---
 rtl/axi_reorder_remap_cmp_pkg.sv | 69 ++++++
 rtl/cmp_fifo.sv | 45 ++++
 rtl/axi_reorder_remap_cmp.sv | 213 +++++++++++++++++++++
 tb/tb_axi_reorder_remap_cmp.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_reorder_remap_cmp_pkg.sv
// Shared AXI channel and bundle types used by the reorder/remap checker and its bench.
package axi_reorder_remap_cmp_pkg;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned UserWidth = 1;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic [UserWidth-1:0] user;
  } axi_aw_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic [UserWidth-1:0] user;
  } axi_ar_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic                   last;
    logic [UserWidth-1:0]   user;
  } axi_w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [1:0]           resp;
    logic [UserWidth-1:0] user;
  } axi_b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
    logic [UserWidth-1:0] user;
  } axi_r_chan_t;

  typedef struct packed {
    axi_aw_chan_t aw;
    logic         aw_valid;
    axi_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_ar_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    axi_b_chan_t b;
    logic        b_valid;
    axi_r_chan_t r;
    logic        r_valid;
  } axi_rsp_t;

endpackage

// File: rtl/cmp_fifo.sv
// In-order FIFO of an arbitrary payload type; push into full and pop from empty are ignored.
module cmp_fifo #(
  parameter int unsigned Depth = 32,
  parameter type         T     = logic
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output T     o_data,
  output logic o_full,
  output logic o_empty
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  T                r_mem [Depth];
  logic [PtrW-1:0] r_wptr, r_rptr;
  logic [CntW-1:0] r_cnt;
  logic            w_push, w_pop;

  assign o_full  = (r_cnt == CntW'(Depth));
  assign o_empty = (r_cnt == '0);
  assign o_data  = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PtrW'(Depth - 1)) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == PtrW'(Depth - 1)) ? '0 : r_rptr + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/axi_reorder_remap_cmp.sv
// Passive checker: compares manager- and subordinate-side AXI traffic across an ID remapper,
// allowing responses to reorder across IDs but not within one ID.
module axi_reorder_remap_cmp
  import axi_reorder_remap_cmp_pkg::*;
#(
  parameter int unsigned AxiInIdWidth  = 4,
  parameter int unsigned AxiOutIdWidth = 4,
  parameter int unsigned MaxTxns       = 32,
  parameter type aw_chan_t = axi_aw_chan_t,
  parameter type w_chan_t  = axi_w_chan_t,
  parameter type b_chan_t  = axi_b_chan_t,
  parameter type ar_chan_t = axi_ar_chan_t,
  parameter type r_chan_t  = axi_r_chan_t,
  parameter type req_t     = axi_req_t,
  parameter type rsp_t     = axi_rsp_t
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  req_t       mon_mst_req_i,
  input  rsp_t       mon_mst_rsp_i,
  input  req_t       mon_slv_req_i,
  input  rsp_t       mon_slv_rsp_i,
  output logic [5:0] error_o,
  output logic       end_of_sim_o
);
  localparam int unsigned IdxW = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;

  logic w_mst_aw, w_mst_w, w_mst_ar, w_mst_b, w_mst_r;
  logic w_slv_aw, w_slv_w, w_slv_ar, w_slv_b, w_slv_r;

  assign w_mst_aw = mon_mst_req_i.aw_valid && mon_mst_rsp_i.aw_ready;
  assign w_mst_w  = mon_mst_req_i.w_valid  && mon_mst_rsp_i.w_ready;
  assign w_mst_ar = mon_mst_req_i.ar_valid && mon_mst_rsp_i.ar_ready;
  assign w_mst_b  = mon_mst_rsp_i.b_valid  && mon_mst_req_i.b_ready;
  assign w_mst_r  = mon_mst_rsp_i.r_valid  && mon_mst_req_i.r_ready;
  assign w_slv_aw = mon_slv_req_i.aw_valid && mon_slv_rsp_i.aw_ready;
  assign w_slv_w  = mon_slv_req_i.w_valid  && mon_slv_rsp_i.w_ready;
  assign w_slv_ar = mon_slv_req_i.ar_valid && mon_slv_rsp_i.ar_ready;
  assign w_slv_b  = mon_slv_rsp_i.b_valid  && mon_slv_req_i.b_ready;
  assign w_slv_r  = mon_slv_rsp_i.r_valid  && mon_slv_req_i.r_ready;

  aw_chan_t w_aw_head, w_aw_exp, w_aw_act;
  ar_chan_t w_ar_head, w_ar_exp, w_ar_act;
  w_chan_t  w_w_head;
  logic     w_aw_full, w_aw_empty, w_ar_full, w_ar_empty, w_w_full, w_w_empty;

  cmp_fifo #(.Depth(MaxTxns), .T(aw_chan_t)) u_aw_fifo (
    .i_clk(clk_i), .i_rst(rst_i), .i_push(w_mst_aw), .i_data(mon_mst_req_i.aw),
    .i_pop(w_slv_aw), .o_data(w_aw_head), .o_full(w_aw_full), .o_empty(w_aw_empty)
  );
  cmp_fifo #(.Depth(MaxTxns), .T(ar_chan_t)) u_ar_fifo (
    .i_clk(clk_i), .i_rst(rst_i), .i_push(w_mst_ar), .i_data(mon_mst_req_i.ar),
    .i_pop(w_slv_ar), .o_data(w_ar_head), .o_full(w_ar_full), .o_empty(w_ar_empty)
  );
  cmp_fifo #(.Depth(MaxTxns), .T(w_chan_t)) u_w_fifo (
    .i_clk(clk_i), .i_rst(rst_i), .i_push(w_mst_w), .i_data(mon_mst_req_i.w),
    .i_pop(w_slv_w), .o_data(w_w_head), .o_full(w_w_full), .o_empty(w_w_empty)
  );

  // Remap CAM and expected-response stores; r_*_age orders entries by insertion.
  logic [MaxTxns-1:0]       r_map_vld, r_map_rd;
  logic [AxiOutIdWidth-1:0] r_map_slv [MaxTxns];
  logic [AxiInIdWidth-1:0]  r_map_mst [MaxTxns];
  logic [31:0]              r_map_age [MaxTxns];
  logic [MaxTxns-1:0]       r_eb_vld, r_er_vld;
  b_chan_t                  r_eb [MaxTxns];
  r_chan_t                  r_er [MaxTxns];
  logic [31:0]              r_eb_age [MaxTxns];
  logic [31:0]              r_er_age [MaxTxns];
  logic [31:0]              r_age;
  logic [5:0]               r_err;

  logic [IdxW-1:0] w_aw_slot, w_ar_slot, w_eb_slot, w_er_slot;
  logic [IdxW-1:0] w_bmap_idx, w_rmap_idx, w_eb_idx, w_er_idx;
  logic w_aw_slot_ok, w_ar_slot_ok, w_eb_slot_ok, w_er_slot_ok;
  logic w_bmap_hit, w_rmap_hit, w_eb_hit, w_er_hit;
  logic w_map_aw_push, w_map_ar_push, w_eb_push, w_er_push;
  b_chan_t w_eb_new;
  r_chan_t w_er_new;
  logic [5:0] w_err_d;

  always_comb begin
    w_aw_slot = '0; w_aw_slot_ok = 1'b0; w_ar_slot = '0; w_ar_slot_ok = 1'b0;
    w_eb_slot = '0; w_eb_slot_ok = 1'b0; w_er_slot = '0; w_er_slot_ok = 1'b0;
    w_bmap_idx = '0; w_bmap_hit = 1'b0; w_rmap_idx = '0; w_rmap_hit = 1'b0;
    w_eb_idx = '0; w_eb_hit = 1'b0; w_er_idx = '0; w_er_hit = 1'b0;
    for (int i = 0; i < MaxTxns; i++) begin
      if (!r_map_vld[i]) begin
        if (w_slv_aw && !w_aw_slot_ok) begin
          w_aw_slot = IdxW'(i); w_aw_slot_ok = 1'b1;
        end else if (!w_ar_slot_ok) begin
          w_ar_slot = IdxW'(i); w_ar_slot_ok = 1'b1;
        end
      end
      if (!r_eb_vld[i] && !w_eb_slot_ok) begin w_eb_slot = IdxW'(i); w_eb_slot_ok = 1'b1; end
      if (!r_er_vld[i] && !w_er_slot_ok) begin w_er_slot = IdxW'(i); w_er_slot_ok = 1'b1; end
      if (r_map_vld[i] && !r_map_rd[i] &&
          r_map_slv[i] == mon_slv_rsp_i.b.id[AxiOutIdWidth-1:0] &&
          (!w_bmap_hit || r_map_age[i] < r_map_age[w_bmap_idx])) begin
        w_bmap_idx = IdxW'(i); w_bmap_hit = 1'b1;
      end
      if (r_map_vld[i] && r_map_rd[i] &&
          r_map_slv[i] == mon_slv_rsp_i.r.id[AxiOutIdWidth-1:0] &&
          (!w_rmap_hit || r_map_age[i] < r_map_age[w_rmap_idx])) begin
        w_rmap_idx = IdxW'(i); w_rmap_hit = 1'b1;
      end
      if (r_eb_vld[i] && r_eb[i].id == mon_mst_rsp_i.b.id &&
          (!w_eb_hit || r_eb_age[i] < r_eb_age[w_eb_idx])) begin
        w_eb_idx = IdxW'(i); w_eb_hit = 1'b1;
      end
      if (r_er_vld[i] && r_er[i].id == mon_mst_rsp_i.r.id &&
          (!w_er_hit || r_er_age[i] < r_er_age[w_er_idx])) begin
        w_er_idx = IdxW'(i); w_er_hit = 1'b1;
      end
    end
  end

  always_comb begin
    w_aw_exp = w_aw_head;        w_aw_exp.id = '0;
    w_aw_act = mon_slv_req_i.aw; w_aw_act.id = '0;
    w_ar_exp = w_ar_head;        w_ar_exp.id = '0;
    w_ar_act = mon_slv_req_i.ar; w_ar_act.id = '0;
    w_eb_new = mon_slv_rsp_i.b;  w_eb_new.id = '0;
    w_eb_new.id[AxiInIdWidth-1:0] = r_map_mst[w_bmap_idx];
    w_er_new = mon_slv_rsp_i.r;  w_er_new.id = '0;
    w_er_new.id[AxiInIdWidth-1:0] = r_map_mst[w_rmap_idx];
  end

  assign w_map_aw_push = w_slv_aw && !w_aw_empty && w_aw_slot_ok;
  assign w_map_ar_push = w_slv_ar && !w_ar_empty && w_ar_slot_ok;
  assign w_eb_push     = w_slv_b && w_bmap_hit && w_eb_slot_ok;
  assign w_er_push     = w_slv_r && w_rmap_hit && w_er_slot_ok;

  always_comb begin
    w_err_d = r_err;
    if ((w_mst_aw && w_aw_full) || (w_mst_ar && w_ar_full) || (w_mst_w && w_w_full)) begin
      w_err_d[5] = 1'b1;
    end
    if (w_slv_aw) begin
      if (w_aw_empty) w_err_d[5] = 1'b1;
      else begin
        if (w_aw_exp != w_aw_act) w_err_d[0] = 1'b1;
        if (!w_aw_slot_ok)        w_err_d[5] = 1'b1;
      end
    end
    if (w_slv_ar) begin
      if (w_ar_empty) w_err_d[5] = 1'b1;
      else begin
        if (w_ar_exp != w_ar_act) w_err_d[3] = 1'b1;
        if (!w_ar_slot_ok)        w_err_d[5] = 1'b1;
      end
    end
    if (w_slv_w) begin
      if (w_w_empty)                          w_err_d[5] = 1'b1;
      else if (w_w_head != mon_slv_req_i.w)   w_err_d[1] = 1'b1;
    end
    if (w_slv_b && !(w_bmap_hit && w_eb_slot_ok)) w_err_d[5] = 1'b1;
    if (w_slv_r && !(w_rmap_hit && w_er_slot_ok)) w_err_d[5] = 1'b1;
    if (w_mst_b) begin
      if (!w_eb_hit)                              w_err_d[5] = 1'b1;
      else if (r_eb[w_eb_idx] != mon_mst_rsp_i.b) w_err_d[2] = 1'b1;
    end
    if (w_mst_r) begin
      if (!w_er_hit)                              w_err_d[5] = 1'b1;
      else if (r_er[w_er_idx] != mon_mst_rsp_i.r) w_err_d[4] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_map_vld <= '0;
      r_eb_vld  <= '0;
      r_er_vld  <= '0;
      r_age     <= '0;
      r_err     <= '0;
    end else begin
      r_err <= w_err_d;
      if (w_map_aw_push || w_map_ar_push || w_eb_push || w_er_push) r_age <= r_age + 1'b1;
      if (w_slv_b && w_bmap_hit)                           r_map_vld[w_bmap_idx] <= 1'b0;
      if (w_slv_r && w_rmap_hit && mon_slv_rsp_i.r.last)   r_map_vld[w_rmap_idx] <= 1'b0;
      if (w_mst_b && w_eb_hit) r_eb_vld[w_eb_idx] <= 1'b0;
      if (w_mst_r && w_er_hit) r_er_vld[w_er_idx] <= 1'b0;
      if (w_map_aw_push) begin
        r_map_vld[w_aw_slot] <= 1'b1;
        r_map_rd[w_aw_slot]  <= 1'b0;
        r_map_slv[w_aw_slot] <= mon_slv_req_i.aw.id[AxiOutIdWidth-1:0];
        r_map_mst[w_aw_slot] <= w_aw_head.id[AxiInIdWidth-1:0];
        r_map_age[w_aw_slot] <= r_age;
      end
      if (w_map_ar_push) begin
        r_map_vld[w_ar_slot] <= 1'b1;
        r_map_rd[w_ar_slot]  <= 1'b1;
        r_map_slv[w_ar_slot] <= mon_slv_req_i.ar.id[AxiOutIdWidth-1:0];
        r_map_mst[w_ar_slot] <= w_ar_head.id[AxiInIdWidth-1:0];
        r_map_age[w_ar_slot] <= r_age;
      end
      if (w_eb_push) begin
        r_eb_vld[w_eb_slot] <= 1'b1;
        r_eb[w_eb_slot]     <= w_eb_new;
        r_eb_age[w_eb_slot] <= r_age;
      end
      if (w_er_push) begin
        r_er_vld[w_er_slot] <= 1'b1;
        r_er[w_er_slot]     <= w_er_new;
        r_er_age[w_er_slot] <= r_age;
      end
    end
  end

  assign error_o      = r_err;
  assign end_of_sim_o = rst_i || (w_aw_empty && w_ar_empty && w_w_empty &&
                                  !(|r_map_vld) && !(|r_eb_vld) && !(|r_er_vld));
endmodule

// File: tb/tb_axi_reorder_remap_cmp.sv
// Directed bench for the reorder/remap checker: each task drives a scenario and checks flags.
module tb_axi_reorder_remap_cmp;
  import axi_reorder_remap_cmp_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  axi_req_t   mst_req, slv_req;
  axi_rsp_t   mst_rsp, slv_rsp;
  logic [5:0] err;
  logic       eos;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  axi_reorder_remap_cmp #(
    .AxiInIdWidth(4), .AxiOutIdWidth(4), .MaxTxns(32),
    .aw_chan_t(axi_aw_chan_t), .w_chan_t(axi_w_chan_t), .b_chan_t(axi_b_chan_t),
    .ar_chan_t(axi_ar_chan_t), .r_chan_t(axi_r_chan_t), .req_t(axi_req_t), .rsp_t(axi_rsp_t)
  ) dut (
    .clk_i(clk), .rst_i(rst), .mon_mst_req_i(mst_req), .mon_mst_rsp_i(mst_rsp),
    .mon_slv_req_i(slv_req), .mon_slv_rsp_i(slv_rsp), .error_o(err), .end_of_sim_o(eos)
  );

  task automatic clear_bus();
    mst_req = '0; mst_rsp = '0; slv_req = '0; slv_rsp = '0;
  endtask

  // Inputs change #1 after a rising edge, so outputs are sampled there too.
  task automatic tick();
    @(posedge clk); #1;
    clear_bus();
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic set_aw(input bit slv, input logic [3:0] id, input logic [31:0] addr,
                        input logic [7:0] len);
    axi_aw_chan_t aw;
    aw = '0; aw.id = id; aw.addr = addr; aw.len = len; aw.size = 3'd2; aw.burst = 2'b01;
    if (slv) begin slv_req.aw = aw; slv_req.aw_valid = 1'b1; slv_rsp.aw_ready = 1'b1; end
    else     begin mst_req.aw = aw; mst_req.aw_valid = 1'b1; mst_rsp.aw_ready = 1'b1; end
  endtask

  task automatic set_ar(input bit slv, input logic [3:0] id, input logic [31:0] addr,
                        input logic [7:0] len);
    axi_ar_chan_t ar;
    ar = '0; ar.id = id; ar.addr = addr; ar.len = len; ar.size = 3'd2; ar.burst = 2'b01;
    if (slv) begin slv_req.ar = ar; slv_req.ar_valid = 1'b1; slv_rsp.ar_ready = 1'b1; end
    else     begin mst_req.ar = ar; mst_req.ar_valid = 1'b1; mst_rsp.ar_ready = 1'b1; end
  endtask

  task automatic set_w(input bit slv, input logic [31:0] data);
    axi_w_chan_t w;
    w = '0; w.data = data; w.strb = 4'hF; w.last = 1'b1;
    if (slv) begin slv_req.w = w; slv_req.w_valid = 1'b1; slv_rsp.w_ready = 1'b1; end
    else     begin mst_req.w = w; mst_req.w_valid = 1'b1; mst_rsp.w_ready = 1'b1; end
  endtask

  task automatic set_b(input bit slv, input logic [3:0] id, input logic [1:0] resp);
    axi_b_chan_t b;
    b = '0; b.id = id; b.resp = resp;
    if (slv) begin slv_rsp.b = b; slv_rsp.b_valid = 1'b1; slv_req.b_ready = 1'b1; end
    else     begin mst_rsp.b = b; mst_rsp.b_valid = 1'b1; mst_req.b_ready = 1'b1; end
  endtask

  task automatic set_r(input bit slv, input logic [3:0] id, input logic [31:0] data,
                       input logic last);
    axi_r_chan_t r;
    r = '0; r.id = id; r.data = data; r.last = last;
    if (slv) begin slv_rsp.r = r; slv_rsp.r_valid = 1'b1; slv_req.r_ready = 1'b1; end
    else     begin mst_rsp.r = r; mst_rsp.r_valid = 1'b1; mst_req.r_ready = 1'b1; end
  endtask

  task automatic test_reset();
    rst = 1'b1; #1;
    checks++;
    if (eos !== 1'b1) begin errors++; $display("FAIL reset_eos_during: got %b want 1", eos); end
    tick(); rst = 1'b0;
    checks++;
    if (err !== 6'h00) begin errors++; $display("FAIL reset_err: got %b want 000000", err); end
    checks++;
    if (eos !== 1'b1) begin errors++; $display("FAIL reset_eos: got %b want 1", eos); end
  endtask

  task automatic test_write_ok();
    do_reset();
    set_aw(0, 4'd3, 32'h100, 8'd0); tick();
    checks++;
    if (eos !== 1'b0) begin errors++; $display("FAIL wr_eos_busy: got %b want 0", eos); end
    set_w(0, 32'hDEAD_BEEF); tick();
    set_aw(1, 4'd1, 32'h100, 8'd0); set_w(1, 32'hDEAD_BEEF); tick();
    set_b(1, 4'd1, 2'b00); tick();
    set_b(0, 4'd3, 2'b00); tick();
    checks++;
    if (err !== 6'h00) begin errors++; $display("FAIL wr_ok_err: got %b want 000000", err); end
    checks++;
    if (eos !== 1'b1) begin errors++; $display("FAIL wr_ok_eos: got %b want 1", eos); end
  endtask

  task automatic test_ar_mismatch();
    do_reset();
    set_ar(0, 4'd0, 32'h200, 8'd0); tick();
    set_ar(1, 4'd0, 32'h204, 8'd0); tick();
    checks++;
    if (err !== 6'h08) begin errors++; $display("FAIL ar_mismatch: got %b want 001000", err); end
    checks++;
    if (eos !== 1'b0) begin errors++; $display("FAIL ar_mismatch_eos: got %b want 0", eos); end
  endtask

  task automatic test_reorder();
    do_reset();
    set_ar(0, 4'd2, 32'h300, 8'd3); tick();
    set_ar(0, 4'd5, 32'h400, 8'd3); tick();
    set_ar(1, 4'd0, 32'h300, 8'd3); tick();
    set_ar(1, 4'd1, 32'h400, 8'd3); tick();
    for (int i = 0; i < 4; i++) begin set_r(1, 4'd1, 32'h10 + i, i == 3); tick(); end
    for (int i = 0; i < 4; i++) begin set_r(1, 4'd0, 32'h20 + i, i == 3); tick(); end
    // Manager sees mst id 2 (subordinate id 0) first, although it returned second.
    for (int i = 0; i < 4; i++) begin set_r(0, 4'd2, 32'h20 + i, i == 3); tick(); end
    for (int i = 0; i < 4; i++) begin set_r(0, 4'd5, 32'h10 + i, i == 3); tick(); end
    checks++;
    if (err !== 6'h00) begin errors++; $display("FAIL reorder_err: got %b want 000000", err); end
    checks++;
    if (eos !== 1'b1) begin errors++; $display("FAIL reorder_eos: got %b want 1", eos); end
  endtask

  task automatic test_r_order_violation();
    do_reset();
    set_ar(0, 4'd2, 32'h500, 8'd1); tick();
    set_ar(1, 4'd0, 32'h500, 8'd1); tick();
    set_r(1, 4'd0, 32'hA0, 1'b0); tick();
    set_r(1, 4'd0, 32'hA1, 1'b1); tick();
    set_r(0, 4'd2, 32'hA1, 1'b1); tick();
    set_r(0, 4'd2, 32'hA0, 1'b0); tick();
    checks++;
    if (err !== 6'h10) begin errors++; $display("FAIL r_order: got %b want 010000", err); end
  endtask

  task automatic test_b_orphan();
    do_reset();
    set_b(1, 4'd1, 2'b00); tick();
    checks++;
    if (err !== 6'h20) begin errors++; $display("FAIL b_orphan: got %b want 100000", err); end
  endtask

  task automatic test_w_mismatch();
    do_reset();
    set_w(0, 32'h1234); tick();
    set_w(1, 32'h1235); tick();
    checks++;
    if (err !== 6'h02) begin errors++; $display("FAIL w_mismatch: got %b want 000010", err); end
    checks++;
    if (eos !== 1'b1) begin errors++; $display("FAIL w_mismatch_eos: got %b want 1", eos); end
  endtask

  task automatic test_b_mismatch();
    do_reset();
    set_aw(0, 4'd4, 32'h40, 8'd0); tick();
    set_aw(1, 4'd2, 32'h40, 8'd0); tick();
    set_b(1, 4'd2, 2'b00); tick();
    set_b(0, 4'd4, 2'b10); tick();
    checks++;
    if (err !== 6'h04) begin errors++; $display("FAIL b_mismatch: got %b want 000100", err); end
    checks++;
    if (eos !== 1'b1) begin errors++; $display("FAIL b_mismatch_eos: got %b want 1", eos); end
  endtask

  task automatic test_same_cycle_empty();
    do_reset();
    set_aw(0, 4'd1, 32'h80, 8'd0); set_aw(1, 4'd1, 32'h80, 8'd0); tick();
    checks++;
    if (err !== 6'h20) begin errors++; $display("FAIL same_cycle_empty: got %b want 100000", err); end
    checks++;
    if (eos !== 1'b0) begin errors++; $display("FAIL same_cycle_eos: got %b want 0", eos); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_aw(0, 4'd1, 32'h10, 8'd0); tick();
    set_aw(0, 4'd2, 32'h20, 8'd0); set_aw(1, 4'd7, 32'h10, 8'd0); tick();
    set_aw(1, 4'd8, 32'h20, 8'd0); tick();
    set_b(1, 4'd8, 2'b00); tick();
    set_b(1, 4'd7, 2'b01); set_b(0, 4'd2, 2'b00); tick();
    set_b(0, 4'd1, 2'b01); tick();
    checks++;
    if (err !== 6'h00) begin errors++; $display("FAIL b2b_err: got %b want 000000", err); end
    checks++;
    if (eos !== 1'b1) begin errors++; $display("FAIL b2b_eos: got %b want 1", eos); end
  endtask

  task automatic test_aw_overflow();
    do_reset();
    for (int i = 0; i < 32; i++) begin set_aw(0, 4'(i), 32'h1000 + 32'(i), 8'd0); tick(); end
    checks++;
    if (err !== 6'h00) begin errors++; $display("FAIL aw_full_err: got %b want 000000", err); end
    set_aw(0, 4'd0, 32'h2000, 8'd0); tick();
    checks++;
    if (err !== 6'h20) begin errors++; $display("FAIL aw_overflow: got %b want 100000", err); end
    checks++;
    if (eos !== 1'b0) begin errors++; $display("FAIL aw_overflow_eos: got %b want 0", eos); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_aw(0, 4'(i), 32'h3000 + 32'(i), 8'd0); set_w(0, 32'(i)); tick();
    end
    set_aw(1, 4'd9, 32'h3000, 8'd0); tick();
    set_b(0, 4'd9, 2'b00); tick();
    checks++;
    if (err !== 6'h20) begin errors++; $display("FAIL mid_pre_err: got %b want 100000", err); end
    rst = 1'b1; set_aw(0, 4'd5, 32'h4000, 8'd0); #1;
    checks++;
    if (eos !== 1'b1) begin errors++; $display("FAIL mid_rst_eos: got %b want 1", eos); end
    tick(); rst = 1'b0;
    checks++;
    if (err !== 6'h00) begin errors++; $display("FAIL mid_post_err: got %b want 000000", err); end
    checks++;
    if (eos !== 1'b1) begin errors++; $display("FAIL mid_post_eos: got %b want 1", eos); end
  endtask

  initial begin
    clear_bus();
    rst = 1'b1;
    test_reset();
    test_write_ok();
    test_ar_mismatch();
    test_reorder();
    test_r_order_violation();
    test_b_orphan();
    test_w_mismatch();
    test_b_mismatch();
    test_same_cycle_empty();
    test_back_to_back();
    test_aw_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
